clk_period_meter: RTL and testbench

- Receive-side companion to the 4 Hz clock generator: accepts a slow, asynchronous clock or tick signal and measures its period in clk_in (100 MHz) cycles.
- Synchronizes the input, detects rising edges, and reports each period with a one-cycle valid strobe.
- Flags a stopped input via timeout. Used to check generated slow clocks and to feed period values to the hex counter/display path.

---
 rtl/clk_period_meter_pkg.sv | 27 ++
 rtl/clk_period_meter_sync_edge_detect.sv | 82 ++++++++
 rtl/clk_period_meter.sv | 100 ++++++++++
 tb/tb_clk_period_meter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_period_meter_pkg.sv
// ---------------------------------------------------------------------------
// clk_meter_pkg
// Shared types and constants for the clk_period_meter slice.
//   meter_state_t       : FSM states of the period meter (IDLE, MEASURE, STALLED)
//   CLK_IN_HZ           : nominal system clock frequency
//   PERIOD_4HZ          : nominal 4 Hz period expressed in clk_in cycles
//   DEFAULT_TIMEOUT     : stall threshold, twice the nominal 4 Hz period
//   DEFAULT_CNT_W       : default period counter width
//   DEFAULT_SYNC_STAGES : default synchronizer depth
//   DEFAULT_FILTER_LEN  : default glitch filter length (GLITCH_FILTER_EN builds)
// ---------------------------------------------------------------------------
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STALLED
  } meter_state_t;

  localparam int          CLK_IN_HZ           = 100000000;
  localparam int          PERIOD_4HZ          = 25000000;
  localparam int          DEFAULT_CNT_W       = 27;
  localparam logic [26:0] DEFAULT_TIMEOUT     = 27'd50000000;
  localparam int          DEFAULT_SYNC_STAGES = 2;
  localparam int          DEFAULT_FILTER_LEN  = 4;

endpackage

// File: rtl/clk_period_meter_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings the asynchronous sig_in into the clk_in domain, optionally filters
// short glitches, and produces a single-cycle rise strobe per rising edge.
// Optional feature macro: GLITCH_FILTER_EN (filter stage between the
// synchronizer output and the edge detector).
// Ports:
//   clk_in : system clock
//   reset  : synchronous, active-high reset
//   sig_in : asynchronous input signal
//   rise   : combinational strobe, high for one cycle per filtered rising edge
// ---------------------------------------------------------------------------
module sync_edge_detect
  import clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FILTER_LEN  = DEFAULT_FILTER_LEN
) (
  input  logic clk_in,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  // A chain shorter than two flops gives no metastability protection, so
  // the depth is clamped to at least two.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              s_sync;
  logic              filt;
  logic              s_prev;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_in};
    end
  end

  assign s_sync = sync_q[STAGES-1];

`ifdef GLITCH_FILTER_EN
  // The filter output only follows s_sync once FILTER_LEN consecutive
  // samples disagree with it; any sample that agrees restarts the count,
  // so a pulse shorter than FILTER_LEN cycles never reaches the detector.
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [FCW-1:0] filt_cnt;
  logic           filt_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      filt_cnt <= '0;
      filt_q   <= 1'b0;
    end else if (s_sync == filt_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
      filt_q   <= s_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign filt = filt_q;
`else
  assign filt = s_sync;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= filt;
    end
  end

  assign rise = filt & ~s_prev;

endmodule

// File: rtl/clk_period_meter.sv
// ---------------------------------------------------------------------------
// clk_period_meter
// Measures the period of a slow asynchronous clock/tick in clk_in cycles,
// reports each period with a one-cycle valid strobe and flags a stopped
// input via a timeout level.
// Optional feature macro: GLITCH_FILTER_EN (enables the glitch filter in
// sync_edge_detect, adding FILTER_LEN cycles of latency).
// Ports:
//   clk_in       : system clock (100 MHz)
//   reset        : synchronous, active-high reset
//   sig_in       : asynchronous slow clock to measure
//   period_out   : last measured period in clk_in cycles
//   period_valid : one-cycle pulse, period_out updated this cycle
//   locked       : at least one period measured since last reset or stall
//   timeout      : high while the input is stalled
// ---------------------------------------------------------------------------
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int               CNT_W       = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(DEFAULT_TIMEOUT),
  parameter int               SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int               FILTER_LEN  = DEFAULT_FILTER_LEN
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  meter_state_t     state;
  logic [CNT_W-1:0] counter;
  logic             rise;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync_edge_detect (
    .clk_in (clk_in),
    .reset  (reset),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // Counter restarts at 1 on each rise, so at the next rise it holds the
  // exact number of cycles between the two. A rise always takes priority
  // over the timeout check, which lets a period of exactly TIMEOUT be
  // reported. The counter stops at TIMEOUT because the FSM leaves MEASURE
  // there, so it can never wrap.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state   <= MEASURE;
            counter <= CNT_W'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
            period_out   <= counter;
            period_valid <= 1'b1;
            locked       <= 1'b1;
            counter      <= CNT_W'(1);
          end else if (counter == TIMEOUT) begin
            state   <= STALLED;
            timeout <= 1'b1;
            locked  <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        STALLED: begin
          // The partial period that ends here is meaningless, so this
          // rise only re-arms the measurement.
          if (rise) begin
            state   <= MEASURE;
            counter <= CNT_W'(1);
            timeout <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_period_meter
// Self-checking bench for clk_period_meter (TIMEOUT reduced to 1000).
// Honours GLITCH_FILTER_EN when defined for the build.
// ---------------------------------------------------------------------------
module tb_clk_period_meter;

  localparam int CNT_W = 27;
  localparam int TO    = 1000;
  localparam int SYNC  = 2;
  localparam int FL    = 4;
`ifdef GLITCH_FILTER_EN
  localparam int MINH  = FL;
`else
  localparam int MINH  = 1;
`endif

  logic             clk_in = 1'b0;
  logic             reset  = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // monitor records
  int vq_cyc[$];
  int vq_val[$];
  int to_cyc[$];
  int rule_viol = 0;
  logic             prev_valid = 1'b0;
  logic             prev_to    = 1'b0;
  logic [CNT_W-1:0] prev_po    = '0;
  logic             reset_at_edge = 1'b1;

  // reference model results
  int seq_per[$];
  int seq_hi[$];
  int exp_q[$];
  int exp_to;

  clk_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (CNT_W'(TO)),
    .SYNC_STAGES (SYNC),
    .FILTER_LEN  (FL)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .sig_in       (sig_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc           <= cyc + 1;
    reset_at_edge <= reset;
  end

  // Record pulses and timeout onsets; count output-rule violations
  // (valid wider than one cycle, period_out moving without valid).
  always @(negedge clk_in) begin
    if (period_valid) begin
      vq_cyc.push_back(cyc);
      vq_val.push_back(int'(period_out));
    end
    if (period_valid && prev_valid) rule_viol++;
    if (!period_valid && (period_out !== prev_po) && !reset_at_edge) rule_viol++;
    if (timeout && !prev_to) to_cyc.push_back(cyc);
    prev_valid = period_valid;
    prev_to    = timeout;
    prev_po    = period_out;
  end

  initial begin
    #(10 * 90000);
    $display("[TB] FAIL watchdog: simulation exceeded 90000 cycles, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_mon();
    vq_cyc.delete();
    vq_val.delete();
    to_cyc.delete();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    reset  = 1'b0;
    clear_mon();
  endtask

  // Rising edge now, high for hi cycles, next rise per cycles later.
  task automatic send_rise(input int per, input int hi);
    sig_in = 1'b1;
    repeat (hi) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (per - hi) @(negedge clk_in);
  endtask

  // Behavioural model: the first rise after reset only arms; each later
  // gap is reported if it is at most TO, otherwise the meter stalls and
  // the closing rise re-arms without a report.
  task automatic run_seq();
    exp_q.delete();
    exp_to = 0;
    for (int i = 0; i < seq_per.size(); i++) begin
      if (i < seq_per.size() - 1) begin
        if (seq_per[i] <= TO) exp_q.push_back(seq_per[i]);
        else exp_to++;
      end
      send_rise(seq_per[i], seq_hi[i]);
    end
    repeat (12) @(negedge clk_in);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (period_out !== '0) begin n_fail++; $display("[TB] FAIL reset_period_out: got %0d, expected 0", period_out); end
    n_cmp++; if (period_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b, expected 0", period_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_locked: got %b, expected 0", locked); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout: got %b, expected 0", timeout); end
  endtask

  task automatic test_square();
    do_reset();
    seq_per.delete(); seq_hi.delete();
    for (int i = 0; i < 11; i++) begin seq_per.push_back(100); seq_hi.push_back(50); end
    run_seq();
    n_cmp++; if (vq_val.size() !== exp_q.size()) begin n_fail++; $display("[TB] FAIL square_count: got %0d pulses, expected %0d", vq_val.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < vq_val.size(); i++) begin
      n_cmp++; if (vq_val[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL square_period[%0d]: got %0d, expected %0d", i, vq_val[i], exp_q[i]); end
    end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL square_locked: got %b, expected 1", locked); end
    n_cmp++; if (to_cyc.size() !== 0) begin n_fail++; $display("[TB] FAIL square_no_timeout: got %0d onsets, expected 0", to_cyc.size()); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      do_reset();
      seq_per.delete(); seq_hi.delete();
      for (int i = 0; i < 8; i++) begin
        int p;
        p = int'($urandom_range(TO, 2 * MINH + 2));
        seq_per.push_back(p);
        seq_hi.push_back(int'($urandom_range(p - MINH, MINH)));
      end
      run_seq();
      n_cmp++; if (vq_val.size() !== exp_q.size()) begin n_fail++; $display("[TB] FAIL random_count: got %0d pulses, expected %0d", vq_val.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < vq_val.size(); i++) begin
        n_cmp++; if (vq_val[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL random_period[%0d]: got %0d, expected %0d", i, vq_val[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    seq_per.delete(); seq_hi.delete();
    for (int i = 0; i < 4; i++) begin seq_per.push_back(100); seq_hi.push_back(50); end
    run_seq();
    for (int k = 0; k < TO + 200 && to_cyc.size() == 0; k++) @(negedge clk_in);
    n_cmp++; if (to_cyc.size() !== 1) begin n_fail++; $display("[TB] FAIL timeout_onset: got %0d onsets, expected 1", to_cyc.size()); end
    if (to_cyc.size() >= 1 && vq_cyc.size() >= 1) begin
      n_cmp++; if (to_cyc[0] - vq_cyc[$] !== TO) begin n_fail++; $display("[TB] FAIL timeout_delay: got %0d cycles after last pulse, expected %0d", to_cyc[0] - vq_cyc[$], TO); end
    end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_locked: got %b, expected 0", locked); end
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_level: got %b, expected 1", timeout); end
    clear_mon();
    send_rise(100, 10);
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_cleared: got %b, expected 0", timeout); end
    n_cmp++; if (vq_val.size() !== 0) begin n_fail++; $display("[TB] FAIL timeout_rearm_pulse: got %0d pulses, expected 0", vq_val.size()); end
    send_rise(20, 10);
    repeat (12) @(negedge clk_in);
    n_cmp++; if (vq_val.size() !== 1) begin n_fail++; $display("[TB] FAIL timeout_recover_count: got %0d pulses, expected 1", vq_val.size()); end
    if (vq_val.size() >= 1) begin
      n_cmp++; if (vq_val[0] !== 100) begin n_fail++; $display("[TB] FAIL timeout_recover_period: got %0d, expected 100", vq_val[0]); end
    end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_relock: got %b, expected 1", locked); end
  endtask

  task automatic test_boundary();
    // gap of exactly TO is still a valid period
    do_reset();
    seq_per = '{100, TO, 20};
    seq_hi  = '{10, 10, 10};
    run_seq();
    n_cmp++; if (vq_val.size() !== exp_q.size()) begin n_fail++; $display("[TB] FAIL edge_to_count: got %0d pulses, expected %0d", vq_val.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < vq_val.size(); i++) begin
      n_cmp++; if (vq_val[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL edge_to_period[%0d]: got %0d, expected %0d", i, vq_val[i], exp_q[i]); end
    end
    n_cmp++; if (to_cyc.size() !== exp_to) begin n_fail++; $display("[TB] FAIL edge_to_timeouts: got %0d, expected %0d", to_cyc.size(), exp_to); end
    // gap of TO+1 stalls and the closing rise only re-arms
    do_reset();
    seq_per = '{100, TO + 1, 100, 20};
    seq_hi  = '{10, 10, 10, 10};
    run_seq();
    n_cmp++; if (vq_val.size() !== exp_q.size()) begin n_fail++; $display("[TB] FAIL over_to_count: got %0d pulses, expected %0d", vq_val.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < vq_val.size(); i++) begin
      n_cmp++; if (vq_val[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL over_to_period[%0d]: got %0d, expected %0d", i, vq_val[i], exp_q[i]); end
    end
    n_cmp++; if (to_cyc.size() !== exp_to) begin n_fail++; $display("[TB] FAIL over_to_timeouts: got %0d, expected %0d", to_cyc.size(), exp_to); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    seq_per = '{100, 100, 100};
    seq_hi  = '{10, 10, 10};
    run_seq();
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_prelock: got %b, expected 1", locked); end
    send_rise(50, 10);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    n_cmp++; if (period_out !== '0) begin n_fail++; $display("[TB] FAIL mid_period_out: got %0d, expected 0", period_out); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_locked: got %b, expected 0", locked); end
    n_cmp++; if ((period_valid | timeout) !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valid_timeout: got %b%b, expected 00", period_valid, timeout); end
    clear_mon();
    send_rise(100, 10);
    send_rise(20, 10);
    repeat (12) @(negedge clk_in);
    n_cmp++; if (vq_val.size() !== 1) begin n_fail++; $display("[TB] FAIL mid_count: got %0d pulses, expected 1", vq_val.size()); end
    if (vq_val.size() >= 1) begin
      n_cmp++; if (vq_val[0] !== 100) begin n_fail++; $display("[TB] FAIL mid_period: got %0d, expected 100", vq_val[0]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    seq_per.delete(); seq_hi.delete();
    for (int i = 0; i < 8; i++) begin seq_per.push_back(2 * MINH); seq_hi.push_back(MINH); end
    run_seq();
    n_cmp++; if (vq_val.size() !== exp_q.size()) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d pulses, expected %0d", vq_val.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < vq_val.size(); i++) begin
      n_cmp++; if (vq_val[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL b2b_period[%0d]: got %0d, expected %0d", i, vq_val[i], exp_q[i]); end
    end
  endtask

`ifdef GLITCH_FILTER_EN
  task automatic test_glitch();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sig_in = 1'b1; repeat (10) @(negedge clk_in);
      sig_in = 1'b0; repeat (40) @(negedge clk_in);
      sig_in = 1'b1; repeat (2)  @(negedge clk_in);
      sig_in = 1'b0; repeat (48) @(negedge clk_in);
    end
    send_rise(20, 10);
    repeat (12) @(negedge clk_in);
    n_cmp++; if (vq_val.size() !== 2) begin n_fail++; $display("[TB] FAIL glitch_count: got %0d pulses, expected 2", vq_val.size()); end
    for (int i = 0; i < 2 && i < vq_val.size(); i++) begin
      n_cmp++; if (vq_val[i] !== 100) begin n_fail++; $display("[TB] FAIL glitch_period[%0d]: got %0d, expected 100", i, vq_val[i]); end
    end
  endtask
`endif

  task automatic test_output_rules();
    n_cmp++; if (rule_viol !== 0) begin n_fail++; $display("[TB] FAIL output_rules: got %0d violations, expected 0", rule_viol); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_random();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
`ifdef GLITCH_FILTER_EN
    test_glitch();
`endif
    test_output_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
